// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, single-cycle ALU, branch/jump resolution and,
// when the MDU_EN macro is defined, an iterative RV32M multiply/divide unit.
module ex_stage_md #(
   parameter int XLEN    = 32,
   parameter int MD_ITER = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      alu_maine,
   input  logic            alu_sgne,
   input  logic [2:0]      func3e,
   input  logic [XLEN-1:0] instr_lui_e,
   input  logic            instr_auipc_e,
   input  logic            regwr_sgne,
   input  logic            jumpe,
   input  logic            branche,
   input  logic            jalre,
   input  logic            md_e,
   input  logic [XLEN-1:0] rd_data1e,
   input  logic [XLEN-1:0] rd_data2e,
   input  logic [XLEN-1:0] pce,
   input  logic [XLEN-1:0] imm_exte,
   input  logic [XLEN-1:0] pc_4e,
   input  logic [1:0]      fwd_ae,
   input  logic [1:0]      fwd_be,
   input  logic [XLEN-1:0] resultw,
   input  logic [XLEN-1:0] alu_resultm,
   output logic [XLEN-1:0] alu_resulte,
   output logic [XLEN-1:0] wr_datae,
   output logic [XLEN-1:0] pc_targete,
   output logic            pc_srce,
   output logic            md_stall,
   output logic            md_busy
);
   localparam int SW = $clog2(XLEN);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_LUI  = 4'd10;

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] alu_out;
   logic [XLEN-1:0] base_result;
   logic [XLEN-1:0] jalr_sum;
   logic            br_taken;
   logic            unused_ok;

   always_comb begin
      case (fwd_ae)
         2'b01:   src_a = resultw;
         2'b10:   src_a = alu_resultm;
         default: src_a = rd_data1e;
      endcase
      case (fwd_be)
         2'b01:   src_b = resultw;
         2'b10:   src_b = alu_resultm;
         default: src_b = rd_data2e;
      endcase
   end

   assign op_b     = alu_sgne ? imm_exte : src_b;
   assign wr_datae = src_b;

   always_comb begin
      case (alu_maine)
         ALU_ADD:  alu_out = src_a + op_b;
         ALU_SUB:  alu_out = src_a - op_b;
         ALU_SLL:  alu_out = src_a << op_b[SW-1:0];
         ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(op_b))};
         ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (src_a < op_b)};
         ALU_XOR:  alu_out = src_a ^ op_b;
         ALU_SRL:  alu_out = src_a >> op_b[SW-1:0];
         ALU_SRA:  alu_out = $unsigned($signed(src_a) >>> op_b[SW-1:0]);
         ALU_OR:   alu_out = src_a | op_b;
         ALU_AND:  alu_out = src_a & op_b;
         ALU_LUI:  alu_out = instr_lui_e;
         default:  alu_out = '0;
      endcase
   end

   always_comb begin
      if (jumpe)
         base_result = pc_4e;
      else if (instr_auipc_e)
         base_result = pce + instr_lui_e;
      else
         base_result = alu_out;
   end

   // Branches compare the two forwarded register values, never the immediate.
   always_comb begin
      case (func3e)
         3'b000:  br_taken = (src_a == src_b);
         3'b001:  br_taken = (src_a != src_b);
         3'b100:  br_taken = ($signed(src_a) < $signed(src_b));
         3'b101:  br_taken = ($signed(src_a) >= $signed(src_b));
         3'b110:  br_taken = (src_a < src_b);
         3'b111:  br_taken = (src_a >= src_b);
         default: br_taken = 1'b0;
      endcase
   end

   assign jalr_sum   = src_a + imm_exte;
   assign pc_targete = jalre ? {jalr_sum[XLEN-1:1], 1'b0} : (pce + imm_exte);
   assign pc_srce    = jumpe | (branche & br_taken);

`ifdef MDU_EN
   localparam int CW = $clog2(MD_ITER + 1);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} md_state_t;

   md_state_t         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
   logic [2:0]        op_q, op_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   res_q, res_d;

   logic              md_start;
   logic [XLEN-1:0]   st_mag_a, st_mag_b, mag_a_q, mag_b_q;
   logic              a_neg, b_neg;
   logic [XLEN:0]     hi_sum, div_rem, div_trial;
   logic [2*XLEN-1:0] mul_next, div_next, prod;
   logic [XLEN-1:0]   quo, rem, fix_result;

   function automatic logic a_signed(input logic [2:0] op);
      return !(op == 3'b011 || op == 3'b101 || op == 3'b111);
   endfunction

   function automatic logic b_signed(input logic [2:0] op);
      return (op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b110);
   endfunction

   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic sgn);
      return (sgn && x[XLEN-1]) ? (~x + 1'b1) : x;
   endfunction

   assign md_start = (state_q == S_IDLE) && md_e && rst_n;
   assign st_mag_a = magnitude(src_a, a_signed(func3e));
   assign st_mag_b = magnitude(src_b, b_signed(func3e));
   assign a_neg    = a_signed(op_q) && a_q[XLEN-1];
   assign b_neg    = b_signed(op_q) && b_q[XLEN-1];
   assign mag_a_q  = magnitude(a_q, a_signed(op_q));
   assign mag_b_q  = magnitude(b_q, b_signed(op_q));

   // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
   assign hi_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
   assign mul_next  = {hi_sum, acc_q[XLEN-1:1]};
   assign div_rem   = acc_q[2*XLEN-1:XLEN-1];
   assign div_trial = div_rem - {1'b0, mag_b_q};
   assign div_next  = div_trial[XLEN] ? {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   assign prod = (a_neg ^ b_neg) ? (~acc_q + 1'b1) : acc_q;
   assign quo  = (a_neg ^ b_neg) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
   assign rem  = a_neg ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      case (op_q)
         3'b000:        fix_result = prod[XLEN-1:0];
         3'b001, 3'b010,
         3'b011:        fix_result = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101: fix_result = (b_q == '0) ? '1 : quo;
         default:       fix_result = (b_q == '0) ? a_q : rem;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      acc_d   = acc_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (md_e) begin
               a_d   = src_a;
               b_d   = src_b;
               op_d  = func3e;
               cnt_d = '0;
               if (!func3e[2]) begin
                  state_d = S_MUL;
                  acc_d   = {{XLEN{1'b0}}, st_mag_b};
               end else begin
                  state_d = (src_b == '0) ? S_FIX : S_DIV;
                  acc_d   = {{XLEN{1'b0}}, st_mag_a};
               end
            end
         end
         S_MUL, S_DIV: begin
            acc_d = (state_q == S_MUL) ? mul_next : div_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(MD_ITER - 1)) begin
               cnt_d   = '0;
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            res_d   = fix_result;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
      end
   end

   assign md_stall    = md_start || (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
   assign md_busy     = (state_q != S_IDLE);
   assign alu_resulte = (state_q == S_DONE) ? res_q : base_result;
   assign unused_ok   = ^{regwr_sgne};
`else
   assign md_stall    = 1'b0;
   assign md_busy     = 1'b0;
   assign alu_resulte = base_result;
   assign unused_ok   = ^{regwr_sgne, md_e, clk, rst_n};
`endif

endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: randomized ALU/branch/forwarding stimulus
// against an arithmetic reference model, plus MDU scenarios when MDU_EN is defined.
module tb_ex_stage_md;
   localparam int XLEN    = 32;
   localparam int MD_ITER = 32;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SLT  = 4'd3;
   localparam logic [3:0] OP_SLTU = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_AND  = 4'd9;
   localparam logic [3:0] OP_LUI  = 4'd10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  alu_maine;
   logic        alu_sgne;
   logic [2:0]  func3e;
   logic [31:0] instr_lui_e;
   logic        instr_auipc_e, regwr_sgne, jumpe, branche, jalre, md_e;
   logic [31:0] rd_data1e, rd_data2e, pce, imm_exte, pc_4e;
   logic [1:0]  fwd_ae, fwd_be;
   logic [31:0] resultw, alu_resultm;
   logic [31:0] alu_resulte, wr_datae, pc_targete;
   logic        pc_srce, md_stall, md_busy;

   int checks = 0;
   int errors = 0;

   ex_stage_md #(.XLEN(XLEN), .MD_ITER(MD_ITER)) dut (
      .clk(clk), .rst_n(rst_n), .alu_maine(alu_maine), .alu_sgne(alu_sgne),
      .func3e(func3e), .instr_lui_e(instr_lui_e), .instr_auipc_e(instr_auipc_e),
      .regwr_sgne(regwr_sgne), .jumpe(jumpe), .branche(branche), .jalre(jalre),
      .md_e(md_e), .rd_data1e(rd_data1e), .rd_data2e(rd_data2e), .pce(pce),
      .imm_exte(imm_exte), .pc_4e(pc_4e), .fwd_ae(fwd_ae), .fwd_be(fwd_be),
      .resultw(resultw), .alu_resultm(alu_resultm), .alu_resulte(alu_resulte),
      .wr_datae(wr_datae), .pc_targete(pc_targete), .pc_srce(pc_srce),
      .md_stall(md_stall), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] r,
                                           input logic [31:0] w, input logic [31:0] m);
      if (sel == 2'b01) return w;
      if (sel == 2'b10) return m;
      return r;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] lui);
      int sh;
      sh = int'(b % 32);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLL:  return a << sh;
         OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
         OP_XOR:  return a ^ b;
         OP_SRL:  return a >> sh;
         OP_SRA:  return $unsigned($signed(a) >>> sh);
         OP_OR:   return a | b;
         OP_AND:  return a & b;
         OP_LUI:  return lui;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) < $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      logic            ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      p   = 64'd0;
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic idle_inputs();
      alu_maine = OP_ADD; alu_sgne = 1'b0; func3e = 3'd0; instr_lui_e = 32'd0;
      instr_auipc_e = 1'b0; regwr_sgne = 1'b0; jumpe = 1'b0; branche = 1'b0;
      jalre = 1'b0; md_e = 1'b0; rd_data1e = 32'd0; rd_data2e = 32'd0; pce = 32'd0;
      imm_exte = 32'd0; pc_4e = 32'd0; fwd_ae = 2'b00; fwd_be = 2'b00;
      resultw = 32'd0; alu_resultm = 32'd0;
   endtask

   // Runs one M instruction with operands on the forwarding paths, which are scrambled during the stall.
   task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int cycles, output int stalls, output logic [31:0] res,
                         output logic busy_after);
      @(negedge clk);
      idle_inputs();
      func3e = f3; md_e = 1'b1; regwr_sgne = 1'b1;
      fwd_ae = 2'b10; alu_resultm = a; fwd_be = 2'b01; resultw = b;
      rd_data1e = $urandom; rd_data2e = $urandom;
      #1;
      cycles = 1;
      stalls = md_stall ? 1 : 0;
      while (md_stall && cycles < 100) begin
         @(posedge clk);
         #1;
         alu_resultm = $urandom; resultw = $urandom;
         @(negedge clk);
         cycles++;
         if (md_stall) stalls++;
      end
      res = alu_resulte;
      md_e = 1'b0; fwd_ae = 2'b00; fwd_be = 2'b00;
      @(negedge clk);
      busy_after = md_busy;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      md_e  = 1'b1;
      #3;
      checks++;
      if (md_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b exp 0", md_stall); end
      checks++;
      if (md_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", md_busy); end
      checks++;
      if (alu_resulte !== 32'd0) begin errors++; $display("[TB] FAIL reset_result got %h exp 0", alu_resulte); end
      @(negedge clk);
      md_e = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (md_busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy got %b exp 0", md_busy); end
   endtask

   task automatic test_forwarding();
      logic [31:0] exp_a, exp_b;
      @(negedge clk);
      idle_inputs();
      rd_data1e = 32'd5; fwd_ae = 2'b10; alu_resultm = 32'd9; alu_sgne = 1'b1; imm_exte = 32'd1;
      resultw = 32'd7;
      #1;
      checks++;
      if (alu_resulte !== 32'd10) begin errors++; $display("[TB] FAIL fwd_mem got %h exp %h", alu_resulte, 32'd10); end
      fwd_ae = 2'b11;
      #1;
      checks++;
      if (alu_resulte !== 32'd6) begin errors++; $display("[TB] FAIL fwd_sel11 got %h exp %h", alu_resulte, 32'd6); end
      for (int i = 0; i < 24; i++) begin
         rd_data1e = $urandom; rd_data2e = $urandom; resultw = $urandom; alu_resultm = $urandom;
         fwd_ae = 2'($urandom_range(0, 3)); fwd_be = 2'($urandom_range(0, 3)); alu_sgne = 1'b0;
         exp_a = ref_fwd(fwd_ae, rd_data1e, resultw, alu_resultm);
         exp_b = ref_fwd(fwd_be, rd_data2e, resultw, alu_resultm);
         #1;
         checks++;
         if (wr_datae !== exp_b) begin errors++; $display("[TB] FAIL fwd_wrdata got %h exp %h", wr_datae, exp_b); end
         checks++;
         if (alu_resulte !== exp_a + exp_b) begin errors++; $display("[TB] FAIL fwd_add got %h exp %h", alu_resulte, exp_a + exp_b); end
      end
   endtask

   task automatic test_alu_random();
      logic [31:0] a, b, exp;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         idle_inputs();
         alu_maine = 4'($urandom_range(0, 10)); alu_sgne = 1'($urandom);
         rd_data1e = $urandom; rd_data2e = $urandom; resultw = $urandom; alu_resultm = $urandom;
         fwd_ae = 2'($urandom_range(0, 3)); fwd_be = 2'($urandom_range(0, 3));
         imm_exte = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         instr_lui_e = $urandom & 32'hFFFF_F000; pce = $urandom; pc_4e = pce + 32'd4;
         instr_auipc_e = ($urandom_range(0, 7) == 0);
         jumpe = ($urandom_range(0, 7) == 0);
         a = ref_fwd(fwd_ae, rd_data1e, resultw, alu_resultm);
         b = alu_sgne ? imm_exte : ref_fwd(fwd_be, rd_data2e, resultw, alu_resultm);
         if (jumpe) exp = pc_4e;
         else if (instr_auipc_e) exp = pce + instr_lui_e;
         else exp = ref_alu(alu_maine, a, b, instr_lui_e);
         #1;
         checks++;
         if (alu_resulte !== exp) begin
            errors++;
            $display("[TB] FAIL alu op=%0d got %h exp %h", alu_maine, alu_resulte, exp);
         end
      end
   endtask

   task automatic test_branch();
      logic [31:0] a, b, exp_tgt;
      logic        exp_src;
      @(negedge clk);
      idle_inputs();
      branche = 1'b1; func3e = 3'b100; rd_data1e = 32'hFFFF_FFFF; rd_data2e = 32'd1;
      pce = 32'h0000_2000; imm_exte = 32'h0000_0040;
      #1;
      checks++;
      if (pc_srce !== 1'b1) begin errors++; $display("[TB] FAIL blt_taken got %b exp 1", pc_srce); end
      checks++;
      if (pc_targete !== 32'h0000_2040) begin errors++; $display("[TB] FAIL blt_target got %h exp %h", pc_targete, 32'h2040); end
      func3e = 3'b110;
      #1;
      checks++;
      if (pc_srce !== 1'b0) begin errors++; $display("[TB] FAIL bltu_taken got %b exp 0", pc_srce); end
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         idle_inputs();
         func3e = 3'($urandom); branche = 1'($urandom); jumpe = ($urandom_range(0, 5) == 0);
         jalre = 1'($urandom);
         rd_data1e = $urandom; resultw = $urandom; alu_resultm = $urandom;
         rd_data2e = ($urandom_range(0, 3) == 0) ? rd_data1e : $urandom;
         fwd_ae = 2'($urandom_range(0, 3)); fwd_be = ($urandom_range(0, 1) == 0) ? fwd_ae : 2'($urandom);
         pce = $urandom; imm_exte = $urandom; alu_sgne = 1'b1;
         a = ref_fwd(fwd_ae, rd_data1e, resultw, alu_resultm);
         b = ref_fwd(fwd_be, rd_data2e, resultw, alu_resultm);
         exp_src = jumpe | (branche & ref_taken(func3e, a, b));
         exp_tgt = jalre ? ((a + imm_exte) & 32'hFFFF_FFFE) : (pce + imm_exte);
         #1;
         checks++;
         if (pc_srce !== exp_src) begin errors++; $display("[TB] FAIL br_src f3=%0d got %b exp %b", func3e, pc_srce, exp_src); end
         checks++;
         if (pc_targete !== exp_tgt) begin errors++; $display("[TB] FAIL br_target got %h exp %h", pc_targete, exp_tgt); end
      end
   endtask

   task automatic test_jalr();
      @(negedge clk);
      idle_inputs();
      jumpe = 1'b1; jalre = 1'b1; rd_data1e = 32'h0000_1001; imm_exte = 32'd2; alu_sgne = 1'b1;
      pce = 32'h0000_0500; pc_4e = 32'h0000_0504;
      #1;
      checks++;
      if (pc_targete !== 32'h0000_1002) begin errors++; $display("[TB] FAIL jalr_target got %h exp %h", pc_targete, 32'h1002); end
      checks++;
      if (alu_resulte !== 32'h0000_0504) begin errors++; $display("[TB] FAIL jalr_link got %h exp %h", alu_resulte, 32'h504); end
      checks++;
      if (pc_srce !== 1'b1) begin errors++; $display("[TB] FAIL jalr_src got %b exp 1", pc_srce); end
   endtask

`ifdef MDU_EN
   task automatic check_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      int          cycles, stalls, exp_cycles;
      logic [31:0] res, exp;
      logic        busy_after;
      exp        = ref_md(f3, a, b);
      exp_cycles = (f3[2] && b == 32'd0) ? 3 : MD_ITER + 3;
      run_md(f3, a, b, cycles, stalls, res, busy_after);
      checks++;
      if (res !== exp) begin errors++; $display("[TB] FAIL md_result f3=%0d a=%h b=%h got %h exp %h", f3, a, b, res, exp); end
      checks++;
      if (cycles !== exp_cycles) begin errors++; $display("[TB] FAIL md_latency f3=%0d got %0d exp %0d", f3, cycles, exp_cycles); end
      checks++;
      if (stalls !== exp_cycles - 1) begin errors++; $display("[TB] FAIL md_stall_len f3=%0d got %0d exp %0d", f3, stalls, exp_cycles - 1); end
      checks++;
      if (busy_after !== 1'b0) begin errors++; $display("[TB] FAIL md_idle_after got %b exp 0", busy_after); end
   endtask

   task automatic test_md_directed();
      check_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_md(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check_md(3'd0, 32'd3, 32'hFFFF_FFFC);
      check_md(3'd4, 32'd7, 32'd0);
      check_md(3'd6, 32'hFFFF_FFF9, 32'd2);
      check_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      check_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      check_md(3'd7, 32'd5, 32'd0);
      check_md(3'd5, 32'hFFFF_FFFF, 32'd10);
   endtask

   task automatic test_md_random();
      logic [31:0] a, b;
      for (int i = 0; i < 12; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if (i % 4 == 1) b = 32'($urandom_range(1, 300));
         check_md(3'($urandom), a, b);
      end
   endtask

   task automatic test_md_reset();
      @(negedge clk);
      idle_inputs();
      func3e = 3'b100; md_e = 1'b1; rd_data1e = 32'd1000; rd_data2e = 32'd7;
      repeat (11) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (md_stall !== 1'b0) begin errors++; $display("[TB] FAIL md_reset_stall got %b exp 0", md_stall); end
      checks++;
      if (md_busy !== 1'b0) begin errors++; $display("[TB] FAIL md_reset_busy got %b exp 0", md_busy); end
      @(negedge clk);
      md_e = 1'b0;
      rst_n = 1'b1;
      check_md(3'b100, 32'd1000, 32'd7);
   endtask
`else
   task automatic test_md_disabled();
      logic [31:0] exp;
      @(negedge clk);
      idle_inputs();
      md_e = 1'b1; func3e = 3'b100; rd_data1e = $urandom; rd_data2e = $urandom;
      exp = rd_data1e + rd_data2e;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (md_stall !== 1'b0) begin errors++; $display("[TB] FAIL nomdu_stall got %b exp 0", md_stall); end
         checks++;
         if (md_busy !== 1'b0) begin errors++; $display("[TB] FAIL nomdu_busy got %b exp 0", md_busy); end
         checks++;
         if (alu_resulte !== exp) begin errors++; $display("[TB] FAIL nomdu_result got %h exp %h", alu_resulte, exp); end
      end
      md_e = 1'b0;
   endtask
`endif

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_forwarding();
      test_alu_random();
      test_branch();
      test_jalr();
`ifdef MDU_EN
      test_md_directed();
      test_md_random();
      test_md_reset();
`else
      test_md_disabled();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
